// File: rtl/stream_demux_1to2.sv
// rtl/stream_demux_1to2.sv - 1-to-2 stream demultiplexer with a 2-entry FIFO and a delivered-beat counter per port
//
// Purpose:
//   Routes each accepted upstream beat to the output port chosen by in_sel.
//   Each port buffers beats in its own 2-entry FIFO and counts the beats it has
//   delivered. Outputs come from registers, so a beat reaches its port one cycle
//   after it is accepted.
//
// Ports:
//   clk         in   single clock, rising edge
//   rst_n       in   synchronous active-low reset
//   in_valid    in   upstream beat valid
//   in_ready    out  beat accepted this cycle (combinational)
//   in_sel      in   destination port: 0 -> port 0, 1 -> port 1
//   in_data     in   upstream payload [DATA_W]
//   outN_valid  out  port N head entry valid
//   outN_ready  in   port N consumer ready
//   outN_data   out  port N head entry [DATA_W]
//   outN_cnt    out  beats delivered on port N, wraps modulo 2^CNT_W [CNT_W]

module stream_demux_1to2 #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sel,
  input  logic [DATA_W-1:0] in_data,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic [CNT_W-1:0]  out0_cnt,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic [CNT_W-1:0]  out1_cnt
);

  logic              accept;
  logic [1:0]        full_w;
  logic [1:0]        out_ready_w;
  logic [1:0]        out_valid_w;
  logic [DATA_W-1:0] out_data_w [2];
  logic [CNT_W-1:0]  out_cnt_w  [2];

  // Only the selected port's fullness gates the input. rst_n is folded in so
  // nothing can be accepted while reset is held.
  assign in_ready    = rst_n && !(in_sel ? full_w[1] : full_w[0]);
  assign accept      = in_valid && in_ready;
  assign out_ready_w = {out1_ready, out0_ready};

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [DATA_W-1:0] mem_q [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        occ_q, occ_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              push;
    logic              pop;

    assign push = accept && (in_sel == 1'(p));
    assign pop  = (occ_q != 2'd0) && out_ready_w[p];

    always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      occ_d    = occ_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(1);
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({push, pop})
        2'b10:   occ_d = occ_q + 2'd1;
        2'b01:   occ_d = occ_q - 2'd1;
        default: occ_d = occ_q;
      endcase
    end

    // Reset takes priority, so a pop in the reset cycle is never counted.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
        occ_q    <= 2'd0;
        cnt_q    <= '0;
      end else begin
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
        occ_q    <= occ_d;
        cnt_q    <= cnt_d;
      end
    end

    // Storage carries no reset; stale contents are masked by occupancy.
    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
    end

    assign full_w[p]      = (occ_q == 2'd2);
    assign out_valid_w[p] = (occ_q != 2'd0);
    assign out_data_w[p]  = mem_q[rd_ptr_q];
    assign out_cnt_w[p]   = cnt_q;
  end

  assign out0_valid = out_valid_w[0];
  assign out1_valid = out_valid_w[1];
  assign out0_data  = out_data_w[0];
  assign out1_data  = out_data_w[1];
  assign out0_cnt   = out_cnt_w[0];
  assign out1_cnt   = out_cnt_w[1];

endmodule
